// File: rtl/fetch_unit.sv
// fetch_unit
//
// Fetch stage sitting directly in front of the instruction memory. Owns the PC,
// drives the word address, and registers the returned word together with its PC
// into the fetch/decode register. Handles stall, branch/jump redirect with
// flush, and halts on EBREAK or when the PC leaves the instruction memory.
//
// Parameters
//   RESET_PC    PC loaded on reset (bits [1:0] forced to 0)
//   IMEM_WORDS  instruction memory depth in words; PC >= IMEM_WORDS*4 halts
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   Address       current PC, to instruction memory
//   InstrIn       word returned by memory for Address (same cycle)
//   Stall         hold PC and output register
//   BranchTaken   redirect request, overrides Stall
//   BranchTarget  redirect address, bits [1:0] ignored
//   PCOut         PC of the instruction in Instr
//   Instr         registered instruction word
//   Valid         Instr/PCOut hold a real instruction
//   Halted        fetch stopped
//   FetchCount    number of instructions delivered
//
// Build option
//   FETCH_PERF_CNT_EN  when defined, FetchCount is a wrapping delivery counter;
//                      otherwise it is tied to zero and no counter exists.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one idle cycle after reset release, nothing fetched
// RUN   | fetching: redirect > stall > capture-and-advance
// HALT  | terminal; PC frozen, Valid cleared, only rst leaves

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Address,
    input  logic [31:0] InstrIn,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PCOut,
    output logic [31:0] Instr,
    output logic        Valid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;
    // 33 bits so a memory spanning the whole 4 GiB space cannot overflow the limit
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pc_out_of_range;

    assign Address         = pc;
    assign pc_out_of_range = ({1'b0, pc} >= PC_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BOOT;
            pc     <= BOOT_PC;
            Instr  <= NOP;
            PCOut  <= 32'h0;
            Valid  <= 1'b0;
            Halted <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (BranchTaken) begin
                        pc    <= BranchTarget & 32'hFFFF_FFFC;
                        Instr <= NOP;
                        Valid <= 1'b0;
                    end else if (!Stall) begin
                        if (pc_out_of_range) begin
                            // the word on InstrIn is not real memory; drop it and stop
                            Valid  <= 1'b0;
                            Halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            Instr <= InstrIn;
                            PCOut <= pc;
                            Valid <= 1'b1;
                            pc    <= pc + 32'd4;
                            // EBREAK itself is still delivered once
                            if (InstrIn == EBREAK) begin
                                Halted <= 1'b1;
                                state  <= HALT;
                            end
                        end
                    end
                end
                HALT: begin
                    Valid <= 1'b0;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        capture;
    logic [31:0] fetch_count;

    // same condition under which Valid is loaded with 1 above
    assign capture = (state == RUN) && !BranchTaken && !Stall && !pc_out_of_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
        end else if (capture) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign FetchCount = fetch_count;
`else
    assign FetchCount = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural model of the fetch stage runs
// alongside the main instance and is compared on every falling edge; literal
// expectations at key points pin the model. A second instance with a 4-word
// memory covers the out-of-range halt.

module tb_fetch_unit;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;
    localparam int          DEPTH  = 256;
`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rst_r;
    logic        stall, br;
    logic [31:0] br_tgt;
    logic        stall_r, br_r;
    logic [31:0] tgt_r;

    logic [31:0] addr, instr_in, pcout, instr, fcount;
    logic        valid, halted;
    logic [31:0] addr_r, instr_in_r, pcout_r, instr_r, fcount_r;
    logic        valid_r, halted_r;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return (a < 32'(DEPTH)) ? mem[a[7:2]] : JUNK;
    endfunction

    always_comb instr_in   = mem_read(addr);
    always_comb instr_in_r = mem_read(addr_r);

    fetch_unit dut (
        .clk(clk), .rst(rst), .Address(addr), .InstrIn(instr_in),
        .Stall(stall), .BranchTaken(br), .BranchTarget(br_tgt),
        .PCOut(pcout), .Instr(instr), .Valid(valid), .Halted(halted),
        .FetchCount(fcount)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_r (
        .clk(clk), .rst(rst_r), .Address(addr_r), .InstrIn(instr_in_r),
        .Stall(stall_r), .BranchTaken(br_r), .BranchTarget(tgt_r),
        .PCOut(pcout_r), .Instr(instr_r), .Valid(valid_r), .Halted(halted_r),
        .FetchCount(fcount_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = waiting one cycle after reset, 1 = fetching,
    // 2 = stopped. Reads its own copy of the PC against the memory array.
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_pcout, m_count;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_pc    <= 32'h0;
            m_instr <= NOP;
            m_pcout <= 32'h0;
            m_valid <= 1'b0;
            m_count <= 32'h0;
        end else if (m_phase == 0) begin
            m_phase <= 1;
        end else if (m_phase == 1) begin
            if (br) begin
                m_pc    <= {br_tgt[31:2], 2'b00};
                m_instr <= NOP;
                m_valid <= 1'b0;
            end else if (!stall) begin
                if (m_pc >= 32'(DEPTH * 4)) begin
                    m_valid <= 1'b0;
                    m_phase <= 2;
                end else begin
                    m_instr <= mem_read(m_pc);
                    m_pcout <= m_pc;
                    m_valid <= 1'b1;
                    m_pc    <= m_pc + 32'd4;
                    m_count <= m_count + 32'd1;
                    m_phase <= (mem_read(m_pc) == EBREAK) ? 2 : 1;
                end
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_addr",   addr,           m_pc);
            chk("model_instr",  instr,          m_instr);
            chk("model_pcout",  pcout,          m_pcout);
            chk("model_valid",  {31'b0, valid}, {31'b0, m_valid});
            chk("model_halted", {31'b0, halted}, {31'b0, (m_phase == 2)});
            chk("model_count",  fcount,         CNT_EN ? m_count : 32'h0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rst_r = 1'b0;
        stall = 1'b0; br = 1'b0; br_tgt = 32'h0;
        stall_r = 1'b0; br_r = 1'b0; tgt_r = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = NOP | (32'(i) << 7);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0011_0133;
        mem[2] = 32'h0020_8663;
        mem[3] = 32'h00a0_0193;
        mem[4] = 32'h0040_0213;
        mem[5] = 32'h0052_0233;

        #1 rst = 1'b1; rst_r = 1'b1;
        #2;
        chk("rst_addr",   addr,           32'h0);
        chk("rst_instr",  instr,          NOP);
        chk("rst_pcout",  pcout,          32'h0);
        chk("rst_valid",  {31'b0, valid}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_count",  fcount,         32'h0);
        chk_en = 1'b1;

        // T1: boot cycle, then in-order delivery
        @(posedge clk); #1 rst = 1'b0;
        step(1);
        chk("t1_boot_valid", {31'b0, valid}, 32'h0);
        chk("t1_boot_addr",  addr,           32'h0);
        step(1);
        chk("t1_instr0", instr, 32'h0050_0093);
        chk("t1_pc0",    pcout, 32'h0);
        chk("t1_valid0", {31'b0, valid}, 32'h1);
        step(1);
        chk("t1_instr1", instr, 32'h0011_0133);
        chk("t1_pc1",    pcout, 32'h4);

        // T2: stall holds everything for 3 cycles
        stall = 1'b1;
        step(3);
        chk("t2_instr", instr, 32'h0011_0133);
        chk("t2_pcout", pcout, 32'h4);
        chk("t2_addr",  addr,  32'h8);
        chk("t2_valid", {31'b0, valid}, 32'h1);
        stall = 1'b0;
        step(1);
        chk("t2_instr_after", instr, 32'h0020_8663);
        chk("t2_pc_after",    pcout, 32'h8);

        // T3: redirect with stall, low bits of target dropped
        br = 1'b1; br_tgt = 32'h0000_0012; stall = 1'b1;
        step(1);
        chk("t3_addr",  addr,  32'h10);
        chk("t3_valid", {31'b0, valid}, 32'h0);
        chk("t3_instr", instr, NOP);
        br = 1'b0; stall = 1'b0;
        step(1);
        chk("t3_target_instr", instr, 32'h0040_0213);
        chk("t3_target_pc",    pcout, 32'h10);
        step(1);
        chk("t6_count5", fcount, CNT_EN ? 32'd5 : 32'd0);

        // T6: async reset between edges takes effect immediately
        #2 rst = 1'b1;
        #1;
        chk("t6_addr",   addr,           32'h0);
        chk("t6_instr",  instr,          NOP);
        chk("t6_pcout",  pcout,          32'h0);
        chk("t6_valid",  {31'b0, valid}, 32'h0);
        chk("t6_halted", {31'b0, halted}, 32'h0);
        chk("t6_count",  fcount,         32'h0);

        // T4: EBREAK at 0xC delivered once, then halted for good
        mem[3] = EBREAK;
        @(posedge clk); #1 rst = 1'b0;
        step(1);
        step(4);
        chk("t4_instr",  instr,           EBREAK);
        chk("t4_pcout",  pcout,           32'hC);
        chk("t4_valid",  {31'b0, valid},  32'h1);
        chk("t4_halted", {31'b0, halted}, 32'h1);
        chk("t4_addr",   addr,            32'h10);
        chk("t4_count",  fcount,          CNT_EN ? 32'd4 : 32'd0);
        br = 1'b1; br_tgt = 32'h40;
        step(1);
        chk("t4_valid_off", {31'b0, valid}, 32'h0);
        chk("t4_addr_hold", addr,           32'h10);
        chk("t4_instr_hold", instr,         EBREAK);
        br = 1'b0; stall = 1'b1;
        step(5);
        chk("t4_still_halted", {31'b0, halted}, 32'h1);
        chk("t4_still_invalid", {31'b0, valid}, 32'h0);
        chk("t4_pcout_hold", pcout, 32'hC);
        stall = 1'b0;

        // T5: 4-word memory, PC 0x10 is never captured
        mem[3] = 32'h00a0_0193;
        rst_r = 1'b0;
        step(1);
        chk("t5_boot_valid", {31'b0, valid_r}, 32'h0);
        step(4);
        chk("t5_last_instr", instr_r, 32'h00a0_0193);
        chk("t5_last_pc",    pcout_r, 32'hC);
        chk("t5_last_valid", {31'b0, valid_r},  32'h1);
        chk("t5_not_halted", {31'b0, halted_r}, 32'h0);
        step(1);
        chk("t5_valid",  {31'b0, valid_r},  32'h0);
        chk("t5_halted", {31'b0, halted_r}, 32'h1);
        chk("t5_addr",   addr_r,  32'h10);
        chk("t5_pcout",  pcout_r, 32'hC);
        chk("t5_instr",  instr_r, 32'h00a0_0193);
        chk("t5_count",  fcount_r, CNT_EN ? 32'd4 : 32'd0);
        step(2);
        chk("t5_hold_halted", {31'b0, halted_r}, 32'h1);
        chk("t5_hold_addr",   addr_r, 32'h10);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
